// File: rtl/execute_condition_stage_if.sv
// Decode-to-Execute control bundle between the control/hazard units and the condition stage.
// master drives Decode controls, hazard controls and ALU flags; slave is the Execute stage.
interface execute_condition_stage_if #(
  parameter int ALU_CTRL_W = 2
);
  logic                  i_Flush_Execute;
  logic                  i_Stall_Execute;
  logic [3:0]            i_Cond_Decode;
  logic                  i_PC_Source_Decode;
  logic                  i_Reg_Write_Decode;
  logic                  i_Mem_Write_Decode;
  logic                  i_Mem_To_Reg_Decode;
  logic [ALU_CTRL_W-1:0] i_ALU_Control_Decode;
  logic                  i_ALU_Src_Decode;
  logic [1:0]            i_Flag_Write_Decode;
  logic                  i_No_Write_Decode;
  logic                  i_Branch_Decode;
  logic [3:0]            i_ALU_Flags;
  logic                  o_PC_Source_Execute;
  logic                  o_Reg_Write_Execute;
  logic                  o_Mem_Write_Execute;
  logic                  o_Branch_Taken_Execute;
  logic                  o_Mem_To_Reg_Execute;
  logic [ALU_CTRL_W-1:0] o_ALU_Control_Execute;
  logic                  o_ALU_Src_Execute;
  logic                  o_Cond_Pass_Execute;
  logic [3:0]            o_Flags;

  modport master (
    output i_Flush_Execute, i_Stall_Execute, i_Cond_Decode, i_PC_Source_Decode,
           i_Reg_Write_Decode, i_Mem_Write_Decode, i_Mem_To_Reg_Decode,
           i_ALU_Control_Decode, i_ALU_Src_Decode, i_Flag_Write_Decode,
           i_No_Write_Decode, i_Branch_Decode, i_ALU_Flags,
    input  o_PC_Source_Execute, o_Reg_Write_Execute, o_Mem_Write_Execute,
           o_Branch_Taken_Execute, o_Mem_To_Reg_Execute, o_ALU_Control_Execute,
           o_ALU_Src_Execute, o_Cond_Pass_Execute, o_Flags
  );

  modport slave (
    input  i_Flush_Execute, i_Stall_Execute, i_Cond_Decode, i_PC_Source_Decode,
           i_Reg_Write_Decode, i_Mem_Write_Decode, i_Mem_To_Reg_Decode,
           i_ALU_Control_Decode, i_ALU_Src_Decode, i_Flag_Write_Decode,
           i_No_Write_Decode, i_Branch_Decode, i_ALU_Flags,
    output o_PC_Source_Execute, o_Reg_Write_Execute, o_Mem_Write_Execute,
           o_Branch_Taken_Execute, o_Mem_To_Reg_Execute, o_ALU_Control_Execute,
           o_ALU_Src_Execute, o_Cond_Pass_Execute, o_Flags
  );
endinterface

// File: rtl/execute_condition_stage.sv
// Decode->Execute control register with ARM condition evaluation and the NZCV flags register.
// Gated write/branch controls depend on the registered condition, current flags and stall.
module execute_condition_stage #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter bit         NV_ALWAYS  = 1'b1,
  parameter int         ALU_CTRL_W = 2
) (
  input logic                   i_CLK,
  input logic                   i_NRESET,
  execute_condition_stage_if.slave bus
);

  typedef struct packed {
    logic [3:0]            cond;
    logic                  pc_src;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic [1:0]            flag_write;
    logic                  no_write;
    logic                  branch;
    logic                  valid;
  } ctrl_t;

  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_true_s;
  logic       pass_s;

  // ARM condition codes evaluated against {N,Z,C,V}.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      4'b1111: r = NV_ALWAYS;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next pipeline contents: flush beats stall, stall holds, otherwise capture Decode.
  always_comb begin
    ctrl_d = ctrl_q;
    if (bus.i_Flush_Execute) begin
      ctrl_d = '0;
    end else if (bus.i_Stall_Execute) begin
      ctrl_d = ctrl_q;
    end else begin
      ctrl_d.cond       = bus.i_Cond_Decode;
      ctrl_d.pc_src     = bus.i_PC_Source_Decode;
      ctrl_d.reg_write  = bus.i_Reg_Write_Decode;
      ctrl_d.mem_write  = bus.i_Mem_Write_Decode;
      ctrl_d.mem_to_reg = bus.i_Mem_To_Reg_Decode;
      ctrl_d.alu_ctrl   = bus.i_ALU_Control_Decode;
      ctrl_d.alu_src    = bus.i_ALU_Src_Decode;
      ctrl_d.flag_write = bus.i_Flag_Write_Decode;
      ctrl_d.no_write   = bus.i_No_Write_Decode;
      ctrl_d.branch     = bus.i_Branch_Decode;
      ctrl_d.valid      = 1'b1;
    end
  end

  assign cond_true_s = cond_check(ctrl_q.cond, flags_q);
  assign pass_s      = cond_true_s & ctrl_q.valid & ~bus.i_Stall_Execute;

  // Only a passing instruction may update flags; each half is selected independently.
  always_comb begin
    flags_d = flags_q;
    if (pass_s) begin
      if (ctrl_q.flag_write[1]) begin
        flags_d[3:2] = bus.i_ALU_Flags[3:2];
      end else begin
        flags_d[3:2] = flags_q[3:2];
      end
      if (ctrl_q.flag_write[0]) begin
        flags_d[1:0] = bus.i_ALU_Flags[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // Pipeline and flags state.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      ctrl_q  <= '0;
      flags_q <= FLAG_RESET;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  assign bus.o_PC_Source_Execute    = ctrl_q.pc_src & pass_s;
  assign bus.o_Reg_Write_Execute    = ctrl_q.reg_write & pass_s & ~ctrl_q.no_write;
  assign bus.o_Mem_Write_Execute    = ctrl_q.mem_write & pass_s;
  assign bus.o_Branch_Taken_Execute = ctrl_q.branch & pass_s;
  assign bus.o_Mem_To_Reg_Execute   = ctrl_q.mem_to_reg;
  assign bus.o_ALU_Control_Execute  = ctrl_q.alu_ctrl;
  assign bus.o_ALU_Src_Execute      = ctrl_q.alu_src;
  assign bus.o_Cond_Pass_Execute    = pass_s;
  assign bus.o_Flags                = flags_q;

endmodule

// File: tb/tb_execute_condition_stage.sv
// Bench for execute_condition_stage: instruction table with a scoreboard queue, plus
// hand-written reset, stall/flush and mid-stream reset sequences.
module tb_execute_condition_stage;

  localparam logic [3:0] FRST = 4'b0010;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  execute_condition_stage_if #(.ALU_CTRL_W(2)) bus ();

  execute_condition_stage #(
    .FLAG_RESET(FRST),
    .NV_ALWAYS (1'b0),
    .ALU_CTRL_W(2)
  ) dut (
    .i_CLK   (clk),
    .i_NRESET(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs: {pc, rw, mw, bt, pass, m2r, alu[1:0], src, flags[3:0]}
  logic [12:0] obs_s;
  assign obs_s = {bus.o_PC_Source_Execute, bus.o_Reg_Write_Execute, bus.o_Mem_Write_Execute,
                  bus.o_Branch_Taken_Execute, bus.o_Cond_Pass_Execute, bus.o_Mem_To_Reg_Execute,
                  bus.o_ALU_Control_Execute, bus.o_ALU_Src_Execute, bus.o_Flags};

  // ctl = {pc, rw, mw, m2r, src, nw, br}; eg = expected {pc, rw, mw, bt, pass}
  typedef struct {
    logic [3:0]  cond;
    logic [6:0]  ctl;
    logic [1:0]  alu;
    logic [1:0]  fw;
    logic [3:0]  af;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [12:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic vec_t mk(input logic [3:0] cond, input logic [6:0] ctl, input logic [1:0] alu,
                              input logic [1:0] fw, input logic [3:0] af,
                              input logic [4:0] eg, input logic [3:0] ef);
    vec_t v;
    v.cond = cond;
    v.ctl  = ctl;
    v.alu  = alu;
    v.fw   = fw;
    v.af   = af;
    v.exp  = {eg, ctl[3], alu, ctl[2], ef};
    return v;
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    total++;
    if (obs_s !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (pc rw mw bt pass m2r alu src nzcv)", name, obs_s, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic stall, input logic [3:0] cond,
                       input logic [6:0] ctl, input logic [1:0] alu, input logic [1:0] fw,
                       input logic [3:0] af);
    bus.i_Flush_Execute      = flush;
    bus.i_Stall_Execute      = stall;
    bus.i_Cond_Decode        = cond;
    bus.i_PC_Source_Decode   = ctl[6];
    bus.i_Reg_Write_Decode   = ctl[5];
    bus.i_Mem_Write_Decode   = ctl[4];
    bus.i_Mem_To_Reg_Decode  = ctl[3];
    bus.i_ALU_Src_Decode     = ctl[2];
    bus.i_No_Write_Decode    = ctl[1];
    bus.i_Branch_Decode      = ctl[0];
    bus.i_ALU_Control_Decode = alu;
    bus.i_Flag_Write_Decode  = fw;
    bus.i_ALU_Flags          = af;
  endtask

  initial begin
    sb_t e;
    total = 0;
    bad   = 0;

    // af on each row is the ALU result of the instruction already in Execute (the previous row).
    vecs.push_back(mk(4'hE, 7'b0100100, 2'b01, 2'b11, 4'b1111, 5'b01001, 4'b0010)); // SUBS
    vecs.push_back(mk(4'h0, 7'b0000001, 2'b00, 2'b00, 4'b0100, 5'b00011, 4'b0100)); // BEQ taken
    vecs.push_back(mk(4'h1, 7'b0000001, 2'b00, 2'b00, 4'b1111, 5'b00000, 4'b0100)); // BNE
    vecs.push_back(mk(4'hE, 7'b0100010, 2'b10, 2'b11, 4'b0000, 5'b00001, 4'b0100)); // CMP
    vecs.push_back(mk(4'hB, 7'b0100000, 2'b00, 2'b00, 4'b1000, 5'b01001, 4'b1000)); // ADDLT
    vecs.push_back(mk(4'hC, 7'b0010000, 2'b00, 2'b11, 4'b0000, 5'b00000, 4'b1000)); // STRGT
    vecs.push_back(mk(4'hE, 7'b0100000, 2'b00, 2'b11, 4'b0110, 5'b01001, 4'b1000)); // ADDS
    vecs.push_back(mk(4'hE, 7'b0100000, 2'b00, 2'b11, 4'b1111, 5'b01001, 4'b1111));
    vecs.push_back(mk(4'hE, 7'b0100000, 2'b00, 2'b10, 4'b1111, 5'b01001, 4'b1111)); // NZ only
    vecs.push_back(mk(4'hF, 7'b1000001, 2'b00, 2'b00, 4'b0000, 5'b00000, 4'b0011)); // NV never
    vecs.push_back(mk(4'h8, 7'b1001100, 2'b11, 2'b00, 4'b1100, 5'b10001, 4'b0011)); // HI
    vecs.push_back(mk(4'h9, 7'b0000001, 2'b00, 2'b00, 4'b0101, 5'b00000, 4'b0011)); // LS
    vecs.push_back(mk(4'hA, 7'b0100000, 2'b00, 2'b00, 4'b0000, 5'b00000, 4'b0011)); // GE
    vecs.push_back(mk(4'hD, 7'b0010000, 2'b00, 2'b00, 4'b1010, 5'b00101, 4'b0011)); // LE
    vecs.push_back(mk(4'h4, 7'b0100000, 2'b00, 2'b00, 4'b1010, 5'b00000, 4'b0011)); // MI
    vecs.push_back(mk(4'h5, 7'b0100000, 2'b00, 2'b00, 4'b1010, 5'b01001, 4'b0011)); // PL
    vecs.push_back(mk(4'h2, 7'b0100000, 2'b00, 2'b00, 4'b1010, 5'b01001, 4'b0011)); // CS
    vecs.push_back(mk(4'h6, 7'b0100000, 2'b00, 2'b00, 4'b1010, 5'b01001, 4'b0011)); // VS
    vecs.push_back(mk(4'h3, 7'b0100000, 2'b00, 2'b00, 4'b1010, 5'b00000, 4'b0011)); // CC
    vecs.push_back(mk(4'h7, 7'b0100000, 2'b00, 2'b00, 4'b1010, 5'b00000, 4'b0011)); // VC
    vecs.push_back(mk(4'hE, 7'b0100000, 2'b00, 2'b01, 4'b1010, 5'b01001, 4'b0011)); // CV only
    vecs.push_back(mk(4'h6, 7'b0000001, 2'b00, 2'b00, 4'b1101, 5'b00011, 4'b0001)); // BVS
    vecs.push_back(mk(4'h0, 7'b0000001, 2'b00, 2'b00, 4'b0000, 5'b00000, 4'b0001)); // BEQ not

    // Reset held with every input high.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 4'hF, 7'h7F, 2'b11, 2'b11, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", {9'd0, FRST});
    rst_n = 1'b1;
    #1;
    check("reset_release", {9'd0, FRST});
    drive(1'b0, 1'b0, 4'h0, 7'h00, 2'b00, 2'b00, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, vecs[i].cond, vecs[i].ctl, vecs[i].alu, vecs[i].fw, vecs[i].af);
      e.idx = i;
      e.exp = vecs[i].exp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d", e.idx), e.exp);
      end
    end

    // Load an instruction, then stall it for two cycles while Decode changes.
    @(negedge clk);
    drive(1'b0, 1'b0, 4'hE, 7'b1111101, 2'b10, 2'b11, 4'b0000);
    @(posedge clk); #1;
    check("stall_load", 13'b1_1_1_1_1_1_10_1_0001);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 4'h0, 7'h00, 2'b00, 2'b00, 4'b1111);
      @(posedge clk); #1;
      check($sformatf("stall_hold%0d", k), 13'b0_0_0_0_0_1_10_1_0001);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hE, 7'h7F, 2'b11, 2'b11, 4'b1111);
    @(posedge clk); #1;
    check("flush_stall", {9'd0, 4'b0001});
    drive(1'b0, 1'b0, 4'hE, 7'h7F, 2'b11, 2'b11, 4'b1111);
    #1;
    check("flush_empty", {9'd0, 4'b0001});

    // Flush alone: the executing instruction still updates flags, the Decode one is dropped.
    @(negedge clk);
    drive(1'b0, 1'b0, 4'hE, 7'b0100000, 2'b00, 2'b11, 4'b0000);
    @(posedge clk); #1;
    check("pre_flush", 13'b0_1_0_0_1_0_00_0_0001);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hE, 7'b0100000, 2'b00, 2'b11, 4'b0110);
    @(posedge clk); #1;
    check("flush_only", {9'd0, 4'b0110});

    // Reset asserted mid-cycle discards the in-flight flag-setting instruction.
    @(negedge clk);
    drive(1'b0, 1'b0, 4'hE, 7'b0100000, 2'b00, 2'b11, 4'b0000);
    @(posedge clk); #1;
    check("pre_reset", 13'b0_1_0_0_1_0_00_0_0110);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'hE, 7'b0100000, 2'b00, 2'b11, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", {9'd0, FRST});
    @(posedge clk); #1;
    check("mid_reset_edge", {9'd0, FRST});
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 7'h00, 2'b00, 2'b00, 4'h0);
    @(posedge clk); #1;
    check("post_reset", {9'd0, FRST});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
